alu: RTL and testbench

- Registered, parameterised two-operand signed ALU with a 1-cycle latency.
- Two enable bits (a_en, b_en) select one of three operation sets.
- a_op or b_op selects the operation within the active set.
- Sits behind the ALU bus interface; the bench drives inputs and samples C on the rising edge of clk.

---
 rtl/alu.sv | 135 +++++++++++++
 tb/tb_alu.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/alu.sv
// Registered two-operand signed ALU.
// Operands are sign-extended to OUT_WIDTH, one of three operation sets is
// chosen by {a_en, b_en}, and the selected result is captured in a single
// OUT_WIDTH register. rst_n is a synchronous, active-high reset despite
// its name.
module alu #(
    parameter int IN_WIDTH  = 5,
    parameter int OUT_WIDTH = 6
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  A,
    input  logic [IN_WIDTH-1:0]  B,
    input  logic                 a_en,
    input  logic                 b_en,
    input  logic [2:0]           a_op,
    input  logic [1:0]           b_op,
    input  logic                 ALU_en,
    output logic [OUT_WIDTH-1:0] C
);

    // The result must hold at least one extra bit beyond the operands so
    // that the sign extension below has a non-zero replication count.
    if (OUT_WIDTH < IN_WIDTH + 1) begin : g_width_check
        $error("alu: OUT_WIDTH must be at least IN_WIDTH+1");
    end

    // Operation set decoded from {ALU_en, a_en, b_en}.
    typedef enum logic [1:0] {
        SET_NONE = 2'd0,
        SET_A    = 2'd1,
        SET_B1   = 2'd2,
        SET_B2   = 2'd3
    } op_set_e;

    // Set A opcodes.
    typedef enum logic [2:0] {
        A_ADD  = 3'd0,
        A_SUB  = 3'd1,
        A_XOR  = 3'd2,
        A_AND  = 3'd3,
        A_OR   = 3'd4,
        A_XNOR = 3'd5
    } a_opc_e;

    // Set B1 opcodes.
    typedef enum logic [1:0] {
        B1_NAND = 2'd0,
        B1_ADD0 = 2'd1,
        B1_ADD1 = 2'd2
    } b1_opc_e;

    // Set B2 opcodes.
    typedef enum logic [1:0] {
        B2_XOR  = 2'd0,
        B2_XNOR = 2'd1,
        B2_DECA = 2'd2,
        B2_INCB = 2'd3
    } b2_opc_e;

    logic [OUT_WIDTH-1:0] a_ext;
    logic [OUT_WIDTH-1:0] b_ext;
    logic [OUT_WIDTH-1:0] sum_ab;
    logic [OUT_WIDTH-1:0] diff_ab;
    logic [OUT_WIDTH-1:0] xor_ab;
    logic [OUT_WIDTH-1:0] c_d;
    logic [OUT_WIDTH-1:0] c_q;
    op_set_e              op_set;

    assign a_ext   = {{(OUT_WIDTH-IN_WIDTH){A[IN_WIDTH-1]}}, A};
    assign b_ext   = {{(OUT_WIDTH-IN_WIDTH){B[IN_WIDTH-1]}}, B};
    assign sum_ab  = a_ext + b_ext;
    assign diff_ab = a_ext - b_ext;
    assign xor_ab  = a_ext ^ b_ext;

    // Decode the active operation set; anything undefined (including X/Z on
    // a control bit) falls to SET_NONE, which yields a zero result.
    always_comb begin
        op_set = SET_NONE;
        case ({ALU_en, a_en, b_en})
            3'b110:  op_set = SET_A;
            3'b101:  op_set = SET_B1;
            3'b111:  op_set = SET_B2;
            default: op_set = SET_NONE;
        endcase
    end

    // Result mux: compute the next value of C for the selected operation.
    always_comb begin
        c_d = '0;
        case (op_set)
            SET_A: begin
                case (a_op)
                    A_ADD:   c_d = sum_ab;
                    A_SUB:   c_d = diff_ab;
                    A_XOR:   c_d = xor_ab;
                    A_AND:   c_d = a_ext & b_ext;
                    A_OR:    c_d = a_ext | b_ext;
                    A_XNOR:  c_d = ~xor_ab;
                    default: c_d = '0;
                endcase
            end
            SET_B1: begin
                case (b_op)
                    B1_NAND: c_d = ~(a_ext & b_ext);
                    B1_ADD0: c_d = sum_ab;
                    B1_ADD1: c_d = sum_ab;
                    default: c_d = '0;
                endcase
            end
            SET_B2: begin
                case (b_op)
                    B2_XOR:  c_d = xor_ab;
                    B2_XNOR: c_d = ~xor_ab;
                    B2_DECA: c_d = a_ext - OUT_WIDTH'(1);
                    B2_INCB: c_d = b_ext + OUT_WIDTH'(2);
                    default: c_d = '0;
                endcase
            end
            default: c_d = '0;
        endcase
    end

    // Result register; synchronous reset (active-high rst_n) wins over all.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            c_q <= '0;
        end else begin
            c_q <= c_d;
        end
    end

    assign C = c_q;

endmodule

// File: tb/tb_alu.sv
// Scoreboard bench for alu: each driven operation pushes its expected
// result, which is popped and compared against C one edge later.
module tb_alu;

    localparam int IW = 5;
    localparam int OW = 6;

    logic          clk;
    logic          rst_n;
    logic [IW-1:0] A;
    logic [IW-1:0] B;
    logic          a_en;
    logic          b_en;
    logic [2:0]    a_op;
    logic [1:0]    b_op;
    logic          ALU_en;
    logic [OW-1:0] C;

    typedef struct {
        string         tag;
        logic [OW-1:0] val;
    } exp_t;

    exp_t exp_q[$];
    int   n_tests;
    int   n_fail;

    alu #(.IN_WIDTH(IW), .OUT_WIDTH(OW)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .A      (A),
        .B      (B),
        .a_en   (a_en),
        .b_en   (b_en),
        .a_op   (a_op),
        .b_op   (b_op),
        .ALU_en (ALU_en),
        .C      (C)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Compare one observed value with its expected value.
    task automatic check(input string tag, input logic [OW-1:0] got,
                         input logic [OW-1:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: C=%b expected %b", tag, got, exp);
        end
    endtask

    // Reference model working on plain integers.
    function automatic logic [OW-1:0] model(input bit rst, input bit en,
                                            input bit ae, input bit be,
                                            input logic [2:0] aop,
                                            input logic [1:0] bop,
                                            input logic [IW-1:0] a,
                                            input logic [IW-1:0] b);
        int x;
        int y;
        int r;
        x = $signed(a);
        y = $signed(b);
        r = 0;
        if (!rst && en) begin
            if (ae && !be) begin
                case (aop)
                    3'd0: r = x + y;
                    3'd1: r = x - y;
                    3'd2: r = x ^ y;
                    3'd3: r = x & y;
                    3'd4: r = x | y;
                    3'd5: r = ~(x ^ y);
                    default: r = 0;
                endcase
            end else if (!ae && be) begin
                case (bop)
                    2'd0: r = ~(x & y);
                    2'd1: r = x + y;
                    2'd2: r = x + y;
                    default: r = 0;
                endcase
            end else if (ae && be) begin
                case (bop)
                    2'd0: r = x ^ y;
                    2'd1: r = ~(x ^ y);
                    2'd2: r = x - 1;
                    default: r = y + 2;
                endcase
            end
        end
        return r[OW-1:0];
    endfunction

    // Drive one operation, push its expectation, then check after the edge.
    task automatic step(input string tag, input bit rst, input bit en,
                        input bit ae, input bit be, input logic [2:0] aop,
                        input logic [1:0] bop, input int a, input int b,
                        input bit use_fixed, input logic [OW-1:0] fixed);
        exp_t e;
        rst_n  = rst;
        ALU_en = en;
        a_en   = ae;
        b_en   = be;
        a_op   = aop;
        b_op   = bop;
        A      = a[IW-1:0];
        B      = b[IW-1:0];
        e.tag  = tag;
        e.val  = use_fixed ? fixed : model(rst, en, ae, be, aop, bop, A, B);
        exp_q.push_back(e);
        @(posedge clk);
        #1;
        if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL %s: scoreboard empty", tag);
        end else begin
            e = exp_q.pop_front();
            check(e.tag, C, e.val);
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        n_tests = 0;
        n_fail  = 0;
        rst_n = 1'b1; ALU_en = 1'b0; a_en = 1'b0; b_en = 1'b0;
        a_op = '0; b_op = '0; A = '0; B = '0;

        // Reset holds C at zero even with a live add presented.
        step("rst0", 1, 1, 1, 0, 3'd0, 2'd0, 5, 3, 1, 6'b000000);
        step("rst1", 1, 1, 1, 0, 3'd0, 2'd0, 5, 3, 1, 6'b000000);
        step("rel",  0, 1, 1, 0, 3'd0, 2'd0, 5, 3, 1, 6'b001000);

        // Set A arithmetic and wrap.
        step("a_sub",   0, 1, 1, 0, 3'd1, 2'd0,   3,   5, 1, 6'b111110);
        step("a_addn",  0, 1, 1, 0, 3'd0, 2'd0, -16, -16, 1, 6'b100000);
        step("a_addp",  0, 1, 1, 0, 3'd0, 2'd0,  15,  15, 1, 6'b011110);

        // Set A logic; b_op deliberately non-zero to show it is ignored.
        step("a_xor",   0, 1, 1, 0, 3'd2, 2'd3, 5, 3, 1, 6'b000110);
        step("a_and",   0, 1, 1, 0, 3'd3, 2'd1, 5, 3, 1, 6'b000001);
        step("a_or",    0, 1, 1, 0, 3'd4, 2'd2, 5, 3, 1, 6'b000111);
        step("a_xnor",  0, 1, 1, 0, 3'd5, 2'd0, 5, 3, 1, 6'b111001);
        step("a_ill6",  0, 1, 1, 0, 3'd6, 2'd0, 5, 3, 1, 6'b000000);
        step("a_ill7",  0, 1, 1, 0, 3'd7, 2'd0, 5, 3, 1, 6'b000000);

        // Set B1; a_op deliberately non-zero.
        step("b1_nand", 0, 1, 0, 1, 3'd5, 2'd0, 5, 3, 1, 6'b111110);
        step("b1_add1", 0, 1, 0, 1, 3'd1, 2'd1, 5, 3, 1, 6'b001000);
        step("b1_add2", 0, 1, 0, 1, 3'd7, 2'd2, 5, 3, 1, 6'b001000);
        step("b1_ill",  0, 1, 0, 1, 3'd0, 2'd3, 5, 3, 1, 6'b000000);

        // Set B2.
        step("b2_xor",  0, 1, 1, 1, 3'd3, 2'd0,   5,  3, 1, 6'b000110);
        step("b2_xnor", 0, 1, 1, 1, 3'd0, 2'd1,   5,  3, 1, 6'b111001);
        step("b2_deca", 0, 1, 1, 1, 3'd0, 2'd2, -16,  7, 1, 6'b101111);
        step("b2_incb", 0, 1, 1, 1, 3'd0, 2'd3,  -9, 15, 1, 6'b010001);

        // Disable and no-set cases.
        step("dis",     0, 0, 1, 0, 3'd0, 2'd0, 15, 15, 1, 6'b000000);
        step("dis_b2",  0, 0, 1, 1, 3'd0, 2'd3,  1, 15, 1, 6'b000000);
        step("noset",   0, 1, 0, 0, 3'd0, 2'd1,  5,  3, 1, 6'b000000);

        // Reset mid-stream discards the result that would have been stored.
        step("pre_rst", 0, 1, 1, 0, 3'd0, 2'd0, 7, 7, 1, 6'b001110);
        step("mid_rst", 1, 1, 1, 0, 3'd0, 2'd0, 7, 7, 1, 6'b000000);

        // Back-to-back random operations, one per cycle, checked by model.
        for (int i = 0; i < 400; i++) begin
            step("rand",
                 ($urandom_range(0, 19) == 0),
                 ($urandom_range(0, 7) != 0),
                 1'($urandom), 1'($urandom),
                 3'($urandom), 2'($urandom),
                 $urandom_range(0, 31), $urandom_range(0, 31),
                 0, '0);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
